serial_paralelo_rx: RTL and testbench

SERIAL_PARALELO_RX -- requirements
Module: serial_paralelo_rx

---
 rtl/serial_paralelo_rx_pkg.sv | 24 ++
 rtl/serial_paralelo_rx_sp_shifter.sv | 36 +++
 rtl/serial_paralelo_rx.sv | 133 +++++++++++++
 tb/tb_serial_paralelo_rx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_paralelo_rx_pkg.sv
// rtl/serial_paralelo_rx_pkg.sv - shared phy definitions for the serial-to-parallel receiver
//
// Holds the one-hot receive FSM encoding, the default comma/idle symbol
// and the default number of aligned commas needed before the lane goes
// active. Shared by the phy transmit and receive sides.
package serial_paralelo_rx_pkg;

    // Comma/idle symbol used both for alignment and for idle fill.
    localparam logic [7:0] COM_DEFAULT = 8'hBC;

    // Consecutive byte-aligned commas required before the lane is declared aligned.
    localparam int ALIGN_CNT_DEFAULT = 4;

    // One-hot receive alignment states.
    typedef enum logic [2:0] {
        ST_SEARCH = 3'b001,
        ST_COUNT  = 3'b010,
        ST_ACTIVE = 3'b100
    } state_t;

    // Bit-phase value that marks the last bit of a byte.
    localparam logic [2:0] PHASE_LAST = 3'd7;

endpackage

// File: rtl/serial_paralelo_rx_sp_shifter.sv
// rtl/serial_paralelo_rx_sp_shifter.sv - 8-bit sliding serial window with comma compare
//
// Ports:
//   clk8f    in   serial bit clock, rising edge
//   reset    in   synchronous active-high reset, clears the stored history
//   data_in  in   serial bit, MSB of each byte first
//   win_next out  current 8-bit window {previous 7 bits, data_in}
//   is_com   out  win_next equals the comma symbol
module serial_paralelo_rx_sp_shifter
    import serial_paralelo_rx_pkg::*;
#(
    parameter logic [7:0] COM = COM_DEFAULT
) (
    input  logic       clk8f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] win_next,
    output logic       is_com
);

    // Only the seven youngest bits of the previous window are ever reused,
    // so the oldest bit is dropped rather than stored.
    logic [6:0] sr_tail;

    assign win_next = {sr_tail, data_in};
    assign is_com   = (win_next == COM);

    always_ff @(posedge clk8f) begin
        if (reset) begin
            sr_tail <= '0;
        end else begin
            sr_tail <= win_next[6:0];
        end
    end

endmodule

// File: rtl/serial_paralelo_rx.sv
// rtl/serial_paralelo_rx.sv - serial-to-parallel receiver with comma alignment
//
// Shifts in one bit per clk8f, hunts for the comma symbol at any bit
// offset, confirms ALIGN_CNT byte-aligned commas and then delivers one
// byte every 8 cycles.
//
// Optional build macro: SP_ERR_CNT_EN adds the err_cnt output, a
// saturating count of false locks (COUNT aborted back to SEARCH).
//
// Ports:
//   clk8f       in   serial bit clock, rising edge
//   reset       in   synchronous active-high reset
//   data_in     in   serial bit stream, MSB first
//   data_out    out  [7:0] last delivered byte (held between boundaries)
//   valid_out   out  data_out is a payload byte (not a comma)
//   byte_strobe out  one-cycle pulse when data_out/valid_out update
//   active      out  lane aligned and delivering bytes
//   err_cnt     out  [7:0] false lock count, only with SP_ERR_CNT_EN
module serial_paralelo_rx
    import serial_paralelo_rx_pkg::*;
#(
    parameter logic [7:0] COM       = COM_DEFAULT,
    parameter int         ALIGN_CNT = ALIGN_CNT_DEFAULT
) (
    input  logic       clk8f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
`ifdef SP_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam logic [3:0] ALIGN_TARGET = 4'(ALIGN_CNT);

    state_t     state;
    logic [2:0] phase;
    logic [3:0] com_cnt;
    logic [7:0] win_next;
    logic       is_com;
    logic       boundary;
    logic       false_lock;

    serial_paralelo_rx_sp_shifter #(
        .COM (COM)
    ) u_shifter (
        .clk8f    (clk8f),
        .reset    (reset),
        .data_in  (data_in),
        .win_next (win_next),
        .is_com   (is_com)
    );

    // Phase only has meaning once a comma has fixed the byte grid.
    assign boundary   = (phase == PHASE_LAST);
    assign false_lock = (state == ST_COUNT) && boundary && !is_com;

    always_ff @(posedge clk8f) begin
        if (reset) begin
            state       <= ST_SEARCH;
            phase       <= 3'd0;
            com_cnt     <= 4'd0;
            data_out    <= 8'd0;
            valid_out   <= 1'b0;
            byte_strobe <= 1'b0;
            active      <= 1'b0;
        end else begin
            byte_strobe <= 1'b0;
            case (state)
                ST_SEARCH: begin
                    // Sliding compare at every bit offset; a hit fixes the grid.
                    if (is_com) begin
                        phase   <= 3'd0;
                        com_cnt <= 4'd1;
                        if (ALIGN_TARGET == 4'd1) begin
                            state  <= ST_ACTIVE;
                            active <= 1'b1;
                        end else begin
                            state <= ST_COUNT;
                        end
                    end
                end
                ST_COUNT: begin
                    phase <= phase + 3'd1;
                    // Only whole bytes on the candidate grid are judged.
                    if (boundary) begin
                        if (false_lock) begin
                            state   <= ST_SEARCH;
                            com_cnt <= 4'd0;
                        end else begin
                            com_cnt <= com_cnt + 4'd1;
                            if (com_cnt + 4'd1 == ALIGN_TARGET) begin
                                state  <= ST_ACTIVE;
                                active <= 1'b1;
                            end
                        end
                    end
                end
                ST_ACTIVE: begin
                    phase <= phase + 3'd1;
                    if (boundary) begin
                        data_out    <= win_next;
                        valid_out   <= !is_com;
                        byte_strobe <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_SEARCH;
                    phase     <= 3'd0;
                    com_cnt   <= 4'd0;
                    data_out  <= 8'd0;
                    valid_out <= 1'b0;
                    active    <= 1'b0;
                end
            endcase
        end
    end

`ifdef SP_ERR_CNT_EN
    always_ff @(posedge clk8f) begin
        if (reset) begin
            err_cnt <= 8'd0;
        end else if (false_lock && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// tb/tb_serial_paralelo_rx.sv - self-checking bench for serial_paralelo_rx
module tb_serial_paralelo_rx;

    localparam logic [7:0] COM_V   = 8'hBC;
    localparam int         ALIGN_V = 4;
    localparam int         M_SEARCH = 0;
    localparam int         M_COUNT  = 1;
    localparam int         M_ACTIVE = 2;

    logic       clk8f = 1'b0;
    logic       reset = 1'b1;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;
`ifdef SP_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    serial_paralelo_rx dut (
        .clk8f       (clk8f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .byte_strobe (byte_strobe),
        .active      (active)
`ifdef SP_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    always #5 clk8f = ~clk8f;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural model: the bit history since reset, the bit index of the
    // first comma hit, and byte boundaries every 8 bits after that hit.
    logic [7:0] m_hist = '0;
    int         m_mode = M_SEARCH;
    int         m_t = 0;
    int         m_anchor = 0;
    int         m_n = 0;
    int         m_err = 0;
    logic [7:0] m_data = '0;
    logic       m_valid = 1'b0;
    logic       m_strobe = 1'b0;
    bit         model_ready = 1'b0;

    always @(posedge clk8f) begin
        if (reset) begin
            m_hist = '0; m_mode = M_SEARCH; m_t = 0; m_anchor = 0; m_n = 0; m_err = 0;
            m_data = '0; m_valid = 1'b0; m_strobe = 1'b0;
            model_ready = 1'b1;
        end else begin
            m_hist = {m_hist[6:0], data_in};
            m_t++;
            m_strobe = 1'b0;
            if (m_mode == M_SEARCH) begin
                if (m_hist == COM_V) begin
                    m_anchor = m_t;
                    m_n = 1;
                    m_mode = (ALIGN_V == 1) ? M_ACTIVE : M_COUNT;
                end
            end else if ((m_t - m_anchor) % 8 == 0) begin
                if (m_mode == M_COUNT) begin
                    if (m_hist == COM_V) begin
                        m_n++;
                        if (m_n == ALIGN_V) m_mode = M_ACTIVE;
                    end else begin
                        m_mode = M_SEARCH;
                        m_n = 0;
                        if (m_err < 255) m_err++;
                    end
                end else begin
                    m_data = m_hist;
                    m_valid = (m_hist != COM_V);
                    m_strobe = 1'b1;
                end
            end
        end
    end

    // Bytes the DUT delivered, {valid, data}, for the literal checks.
    logic [8:0] cap_q[$];

    always @(negedge clk8f) begin
        if (model_ready) begin
            check("data_out", 32'(data_out), 32'(m_data));
            check("valid_out", 32'(valid_out), 32'(m_valid));
            check("byte_strobe", 32'(byte_strobe), 32'(m_strobe));
            check("active", 32'(active), 32'(m_mode == M_ACTIVE));
`ifdef SP_ERR_CNT_EN
            check("err_cnt", 32'(err_cnt), 32'(m_err));
`endif
            if (byte_strobe) cap_q.push_back({valid_out, data_out});
        end
    end

    task automatic send_bit(input logic b);
        data_in = b;
        reset = 1'b0;
        @(negedge clk8f);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        data_in = 1'($urandom);
        @(negedge clk8f);
        reset = 1'b0;
        #2;
        cap_q.delete();
    endtask

    task automatic check_cap(input string name, input int idx, input logic [8:0] req);
        if (idx < cap_q.size()) check(name, 32'(cap_q[idx]), 32'(req));
        else check({name, "_missing"}, 32'(cap_q.size()), 32'(idx + 1));
    endtask

    logic [7:0] rb;

    initial begin
        @(negedge clk8f);
        @(negedge clk8f);

        // Reset state
        do_reset();
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_valid_out", 32'(valid_out), 32'h0);
        check("rst_byte_strobe", 32'(byte_strobe), 32'h0);
        check("rst_active", 32'(active), 32'h0);

        // Scenario 1: 4x BC, A5, 3C
        do_reset();
        repeat (3) send_byte(8'hBC);
        for (int i = 7; i >= 1; i--) send_bit(COM_V[i]);
        #2 check("s1_active_before", 32'(active), 32'h0);
        send_bit(COM_V[0]);
        #2 check("s1_active_rise", 32'(active), 32'h1);
        send_byte(8'hA5);
        send_byte(8'h3C);
        #2;
        check("s1_strobes", 32'(cap_q.size()), 32'd2);
        check_cap("s1_byte0", 0, 9'h1A5);
        check_cap("s1_byte1", 1, 9'h13C);

        // Scenario 2: 3 random bits of offset
        do_reset();
        repeat (3) send_bit(1'($urandom));
        repeat (4) send_byte(8'hBC);
        send_byte(8'h00);
        #2 check_cap("s2_byte0", 0, 9'h100);

        // Scenario 3: false lock then realignment
        do_reset();
        send_byte(8'hBC); send_byte(8'hBC); send_byte(8'h11);
        #2 check("s3_active_after_abort", 32'(active), 32'h0);
        repeat (4) send_byte(8'hBC);
        #2 check("s3_active_realigned", 32'(active), 32'h1);
`ifdef SP_ERR_CNT_EN
        check("s3_err_cnt", 32'(err_cnt), 32'd1);
`endif
        send_byte(8'h7E);
        #2 check_cap("s3_byte0", 0, 9'h17E);

        // Scenario 4: idle byte inside payload
        do_reset();
        repeat (4) send_byte(8'hBC);
        send_byte(8'h55); send_byte(8'hBC); send_byte(8'h66);
        #2;
        check_cap("s4_byte0", 0, 9'h155);
        check_cap("s4_byte1", 1, 9'h0BC);
        check_cap("s4_byte2", 2, 9'h166);

        // Scenario 5: reset in the 5th bit of a payload byte
        do_reset();
        repeat (4) send_byte(8'hBC);
        send_byte(8'h9A);
        #2 check("s5_data_before", 32'(data_out), 32'h9A);
        for (int i = 7; i >= 4; i--) send_bit(rb[i % 2]);
        do_reset();
        check("s5_data_out", 32'(data_out), 32'h0);
        check("s5_valid_out", 32'(valid_out), 32'h0);
        check("s5_active", 32'(active), 32'h0);
        repeat (3) send_byte(8'hBC);
        #2 check("s5_active_3bc", 32'(active), 32'h0);
        send_byte(8'hBC);
        #2 check("s5_active_4bc", 32'(active), 32'h1);
        send_byte(8'h42);
        #2 check_cap("s5_byte0", 0, 9'h142);

        // Scenario 6: 300 false locks
        do_reset();
        repeat (300) begin
            send_byte(8'hBC);
            send_byte(8'h00);
        end
        #2 check("s6_active", 32'(active), 32'h0);
`ifdef SP_ERR_CNT_EN
        check("s6_err_cnt_sat", 32'(err_cnt), 32'd255);
`endif

        // Random: aligned payload mixed with idles at a random offset
        do_reset();
        repeat ($urandom_range(0, 7)) send_bit(1'($urandom));
        repeat (4) send_byte(8'hBC);
        for (int i = 0; i < 40; i++) begin
            rb = ($urandom_range(0, 3) == 0) ? 8'hBC : 8'($urandom);
            send_byte(rb);
        end

        // Random: comma-heavy noise to exercise partial locks and aborts
        do_reset();
        for (int i = 0; i < 30; i++) begin
            rb = ($urandom_range(0, 1) == 1) ? 8'hBC : 8'($urandom);
            send_byte(rb);
        end
        repeat (200) send_bit(1'($urandom));

        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
